// File: rtl/sample_store.sv
// sample_store
//
// Circular sample memory plus host readout stage sitting directly behind the
// logic-capture core. While idle, every packet the capture core strobes in is
// stored at the low ADDR_WIDTH bits of its sample number. On readout_start the
// window sampleNumber_Begin..sampleNumber_End is replayed in ascending sample
// order over a valid/ready stream. A window longer than the memory is clipped
// to its newest DEPTH samples.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   write_enable               store samplePacket at sample_number this cycle
//   samplePacket, sample_number  packet and its sample index
//   sampleNumber_Begin/_End    inclusive capture window, latched at start
//   readout_start              begin readout (only honoured while idle)
//   readout_abort              cancel an active readout, no done pulse
//   rd_data, rd_sample_number  current word and its sample index
//   rd_valid, rd_ready         stream handshake, accept = valid & ready
//   rd_last                    current word is the last of the window
//   busy                       readout in progress
//   done                       one-cycle pulse after the last word is accepted
//   truncated                  sticky: window exceeded memory depth
//   write_dropped              sticky: a write arrived during readout

module sample_store #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int ADDR_WIDTH          = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket,
  input  logic [31:0]                    sample_number,
  input  logic [31:0]                    sampleNumber_Begin,
  input  logic [31:0]                    sampleNumber_End,
  input  logic                           readout_start,
  input  logic                           readout_abort,
  output logic [SAMPLE_PACKET_WIDTH-1:0] rd_data,
  output logic [31:0]                    rd_sample_number,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic                           rd_last,
  output logic                           busy,
  output logic                           done,
  output logic                           truncated,
  output logic                           write_dropped
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [31:0]         DEPTH_M1  = 32'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

  state_t                         state_q, state_d;
  logic [31:0]                    cur_q, cur_d;
  logic [ADDR_WIDTH:0]            remaining_q, remaining_d;
  logic                           done_q, done_d;
  logic                           truncated_q, truncated_d;
  logic                           write_dropped_q, write_dropped_d;

  logic [SAMPLE_PACKET_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_PACKET_WIDTH-1:0] mem_rd_q;
  logic                           mem_we;
  logic [31:0]                    span;
  logic                           accept;
  logic                           last_word;

  // Only the low address bits of the sample number select a memory slot; the
  // upper bits are deliberately ignored (circular buffer).
  logic unused_sample_bits;
  assign unused_sample_bits = ^sample_number[31:ADDR_WIDTH];

  // Next-state logic for the readout sequencer. Each word takes a FETCH cycle
  // (memory read issued) followed by a PRESENT cycle (word offered to host).
  // The window span uses modular 32-bit arithmetic so windows crossing the
  // 2^32 sample-number boundary behave like any other window. Abort is
  // applied last so it overrides an accept in the same cycle.
  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    remaining_d     = remaining_q;
    done_d          = 1'b0;
    truncated_d     = truncated_q;
    write_dropped_d = write_dropped_q;
    mem_we          = 1'b0;

    span      = sampleNumber_End - sampleNumber_Begin;
    accept    = (state_q == PRESENT) && rd_ready;
    last_word = (remaining_q == CNT_ONE);

    case (state_q)
      IDLE: begin
        mem_we = write_enable;
        if (readout_start) begin
          state_d         = FETCH;
          write_dropped_d = 1'b0;
          if (span <= DEPTH_M1) begin
            cur_d       = sampleNumber_Begin;
            remaining_d = span[ADDR_WIDTH:0] + CNT_ONE;
            truncated_d = 1'b0;
          end else begin
            // Keep the newest DEPTH samples ending at End.
            cur_d       = sampleNumber_End - DEPTH_M1;
            remaining_d = CNT_DEPTH;
            truncated_d = 1'b1;
          end
        end
      end

      FETCH: begin
        state_d = PRESENT;
        if (write_enable) write_dropped_d = 1'b1;
      end

      PRESENT: begin
        if (write_enable) write_dropped_d = 1'b1;
        if (accept) begin
          cur_d       = cur_q + 32'd1;
          remaining_d = remaining_q - CNT_ONE;
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && readout_abort) begin
      state_d     = IDLE;
      done_d      = 1'b0;
      cur_d       = cur_q;
      remaining_d = remaining_q;
    end
  end

  // Control and status registers; synchronous reset returns every visible
  // output to zero but leaves the sample memory alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cur_q           <= '0;
      remaining_q     <= '0;
      done_q          <= 1'b0;
      truncated_q     <= 1'b0;
      write_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      remaining_q     <= remaining_d;
      done_q          <= done_d;
      truncated_q     <= truncated_d;
      write_dropped_q <= write_dropped_d;
    end
  end

  // Sample memory: one write port, one registered read port. The read
  // register only loads during FETCH, so the presented word stays stable for
  // as long as the host stalls. No reset here so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[sample_number[ADDR_WIDTH-1:0]] <= samplePacket;
    if (state_q == FETCH) mem_rd_q <= mem[cur_q[ADDR_WIDTH-1:0]];
  end

  // Output decode. rd_data is forced to zero outside PRESENT so the reset
  // value is well defined without putting a reset on the RAM read register.
  assign rd_valid         = (state_q == PRESENT);
  assign rd_data          = rd_valid ? mem_rd_q : '0;
  assign rd_sample_number = cur_q;
  assign rd_last          = rd_valid && last_word;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign truncated        = truncated_q;
  assign write_dropped    = write_dropped_q;

endmodule

// File: tb/tb_sample_store.sv
// Directed testbench for sample_store with a 16-entry memory (ADDR_WIDTH=4).
// A small array mirrors what the bench has written so expected readout data
// can be looked up by address.

module tb_sample_store;

  localparam int AW = 4;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write_enable = 1'b0;
  logic [PW-1:0] samplePacket = '0;
  logic [31:0]   sample_number = '0;
  logic [31:0]   sampleNumber_Begin = '0;
  logic [31:0]   sampleNumber_End = '0;
  logic          readout_start = 1'b0;
  logic          readout_abort = 1'b0;
  logic [PW-1:0] rd_data;
  logic [31:0]   rd_sample_number;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          truncated;
  logic          write_dropped;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] model_mem [16];

  sample_store #(
    .SAMPLE_PACKET_WIDTH(PW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .write_enable(write_enable),
    .samplePacket(samplePacket),
    .sample_number(sample_number),
    .sampleNumber_Begin(sampleNumber_Begin),
    .sampleNumber_End(sampleNumber_End),
    .readout_start(readout_start),
    .readout_abort(readout_abort),
    .rd_data(rd_data),
    .rd_sample_number(rd_sample_number),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_last(rd_last),
    .busy(busy),
    .done(done),
    .truncated(truncated),
    .write_dropped(write_dropped)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] sn, input logic [PW-1:0] pkt);
    write_enable  = 1'b1;
    sample_number = sn;
    samplePacket  = pkt;
    tick();
    write_enable  = 1'b0;
    model_mem[sn[3:0]] = pkt;
  endtask

  // Full readout of one window, checking every word, the one-cycle FETCH gap,
  // stability under stalls and the done pulse.
  task automatic run_readout(input string name, input logic [31:0] b, input logic [31:0] e,
                             input logic [31:0] first, input int count,
                             input logic exp_trunc, input bit stall_en);
    logic [31:0]   exp_sn;
    logic [PW-1:0] exp_data;
    logic          exp_last;
    int            stall;
    sampleNumber_Begin = b;
    sampleNumber_End   = e;
    rd_ready           = 1'b0;
    readout_start      = 1'b1;
    tick();
    readout_start      = 1'b0;
    checks++;
    if ({busy, rd_valid, truncated, write_dropped} !== {1'b1, 1'b0, exp_trunc, 1'b0}) begin
      failures++;
      $display("[TB] FAIL %s_start got busy=%0b valid=%0b trunc=%0b wdrop=%0b exp 1 0 %0b 0",
               name, busy, rd_valid, truncated, write_dropped, exp_trunc);
    end
    for (int w = 0; w < count; w++) begin
      exp_sn   = first + 32'(w);
      exp_data = model_mem[exp_sn[3:0]];
      exp_last = (w == count - 1);
      tick();
      stall = stall_en ? int'($urandom_range(0, 3)) : 0;
      for (int s = 0; s <= stall; s++) begin
        checks++;
        if ({rd_valid, rd_last, rd_sample_number, rd_data} !== {1'b1, exp_last, exp_sn, exp_data}) begin
          failures++;
          $display("[TB] FAIL %s_word%0d got v=%0b l=%0b sn=%h d=%h exp v=1 l=%0b sn=%h d=%h",
                   name, w, rd_valid, rd_last, rd_sample_number, rd_data, exp_last, exp_sn, exp_data);
        end
        if (s < stall) tick();
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      checks++;
      if ({rd_valid, busy, done} !== {1'b0, !exp_last, exp_last}) begin
        failures++;
        $display("[TB] FAIL %s_after%0d got valid=%0b busy=%0b done=%0b exp 0 %0b %0b",
                 name, w, rd_valid, busy, done, !exp_last, exp_last);
      end
    end
    tick();
    checks++;
    if ({done, busy, truncated} !== {1'b0, 1'b0, exp_trunc}) begin
      failures++;
      $display("[TB] FAIL %s_end got done=%0b busy=%0b trunc=%0b exp 0 0 %0b",
               name, done, busy, truncated, exp_trunc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({rd_data, rd_sample_number, rd_valid, rd_last, busy, done, truncated, write_dropped} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state got d=%h sn=%h v=%0b l=%0b busy=%0b done=%0b tr=%0b wd=%0b exp all 0",
               rd_data, rd_sample_number, rd_valid, rd_last, busy, done, truncated, write_dropped);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    for (int n = 0; n < 10; n++) do_write(32'(n), 32'hA000 + 32'(n));
    run_readout("basic", 32'd0, 32'd9, 32'd0, 10, 1'b0, 1'b0);
  endtask

  task automatic test_truncate;
    for (int n = 0; n < 40; n++) do_write(32'(n), 32'hA000 + 32'(n));
    run_readout("trunc", 32'd0, 32'd39, 32'd24, 16, 1'b1, 1'b0);
    run_readout("span_full", 32'd20, 32'd35, 32'd20, 16, 1'b0, 1'b0);
    run_readout("span_over", 32'd20, 32'd36, 32'd21, 16, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    do_write(32'hFFFF_FFFE, 32'hB000);
    do_write(32'hFFFF_FFFF, 32'hB001);
    do_write(32'h0000_0000, 32'hB002);
    do_write(32'h0000_0001, 32'hB003);
    run_readout("wrap", 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE, 4, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_readout("backpressure", 32'd2, 32'd6, 32'd2, 5, 1'b0, 1'b1);
    run_readout("single", 32'd5, 32'd5, 32'd5, 1, 1'b0, 1'b0);
  endtask

  task automatic test_write_dropped;
    sampleNumber_Begin = 32'd0;
    sampleNumber_End   = 32'd1;
    readout_start      = 1'b1;
    tick();
    readout_start      = 1'b0;
    write_enable       = 1'b1;
    sample_number      = 32'd0;
    samplePacket       = 32'hDEAD_BEEF;
    tick();
    write_enable       = 1'b0;
    checks++;
    if (write_dropped !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wdrop_set got %0b exp 1", write_dropped);
    end
    rd_ready = 1'b1;
    tick();
    tick();
    tick();
    rd_ready = 1'b0;
    checks++;
    if ({busy, write_dropped} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL wdrop_sticky got busy=%0b wdrop=%0b exp 0 1", busy, write_dropped);
    end
    run_readout("wdrop_reread", 32'd0, 32'd1, 32'd0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    sampleNumber_Begin = 32'd0;
    sampleNumber_End   = 32'd7;
    readout_start      = 1'b1;
    tick();
    readout_start      = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick();
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    tick();
    checks++;
    if ({rd_valid, rd_sample_number} !== {1'b1, 32'd2}) begin
      failures++;
      $display("[TB] FAIL abort_word3 got v=%0b sn=%h exp v=1 sn=00000002", rd_valid, rd_sample_number);
    end
    readout_abort = 1'b1;
    rd_ready      = 1'b1;
    tick();
    readout_abort = 1'b0;
    rd_ready      = 1'b0;
    checks++;
    if ({busy, rd_valid, done} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL abort_idle got busy=%0b valid=%0b done=%0b exp 0 0 0", busy, rd_valid, done);
    end
    run_readout("post_abort", 32'd4, 32'd6, 32'd4, 3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    sampleNumber_Begin = 32'd0;
    sampleNumber_End   = 32'd39;
    readout_start      = 1'b1;
    tick();
    readout_start      = 1'b0;
    write_enable       = 1'b1;
    sample_number      = 32'd3;
    samplePacket       = 32'h1234_5678;
    tick();
    write_enable       = 1'b0;
    reset              = 1'b1;
    tick();
    reset              = 1'b0;
    checks++;
    if ({rd_data, rd_sample_number, rd_valid, rd_last, busy, done, truncated, write_dropped} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid got d=%h sn=%h v=%0b l=%0b busy=%0b done=%0b tr=%0b wd=%0b exp all 0",
               rd_data, rd_sample_number, rd_valid, rd_last, busy, done, truncated, write_dropped);
    end
    run_readout("post_reset", 32'd0, 32'd3, 32'd0, 4, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] sample_store directed test start");
    test_reset();
    test_basic();
    test_truncate();
    test_wrap();
    test_back_to_back();
    test_write_dropped();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
